// File: rtl/tdc_multihit_collector.sv
// tdc_multihit_collector: multi-hit TDC window collector (clk5 domain).
// One coarse-count window per start pulse. Each hit gets a time-of-flight.
// The DEPTH strongest hits by intensity are kept and streamed out as one
// valid/ready/last frame.
// Optional build macro: TDC_HITCNT_EN enables the saturating hits_total_o counter.
//
// state  | meaning
// IDLE   | waiting for start_i; frame results (o_num, ovf_o) held
// ACQ    | window open, counter running, hits ranked into the buffer
// DRAIN  | buffer streamed out in entry order, one beat per handshake
module tdc_multihit_collector #(
    parameter int CNT_W  = 10,
    parameter int FINE_W = 5,
    parameter int INT_W  = 5,
    parameter int DEPTH  = 4,
    parameter int NUM_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk5,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [FINE_W-1:0]       start_fine_i,
    input  logic                    hit_i,
    input  logic [FINE_W-1:0]       hit_fine_i,
    input  logic [INT_W-1:0]        hit_int_i,
    input  logic [CNT_W-1:0]        range_i,
    output logic [CNT_W+FINE_W-1:0] o_data,
    output logic [INT_W-1:0]        o_int,
    output logic [NUM_W-1:0]        o_num,
    output logic                    o_last,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    int_o,
    output logic                    busy_o,
    output logic                    ovf_o,
    output logic [CNT_W-1:0]        hits_total_o
);

    localparam int TOF_W = CNT_W + FINE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_range;
    logic [FINE_W-1:0]  r_sfine;
    logic [NUM_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_beat;
    logic [TOF_W-1:0]   r_tof  [DEPTH];
    logic [INT_W-1:0]   r_eint [DEPTH];
    logic               r_ovf;
    logic               r_int;

    logic               w_start_acc;
    logic               w_hit_acc;
    logic               w_term;
    logic               w_full;
    logic               w_hs;
    logic               w_last_beat;
    logic [TOF_W-1:0]   w_ref;
    logic [TOF_W-1:0]   w_tof;
    logic [IDX_W-1:0]   w_min_idx;
    logic [INT_W-1:0]   w_min_int;

    // A start during DRAIN is ignored; a start in ACQ wins over a same-cycle hit.
    assign w_start_acc = start_i && (r_state != S_DRAIN);
    assign w_hit_acc   = hit_i && (r_state == S_ACQ) && !start_i;
    assign w_term      = (r_state == S_ACQ) && !start_i && (r_cnt == r_range);
    assign w_full      = (r_count == NUM_W'(DEPTH));
    assign w_hs        = o_valid && o_ready;
    assign w_last_beat = (NUM_W'(r_beat) == (r_count - NUM_W'(1)));
    assign w_ref       = {CNT_W'(1), r_sfine};
    assign w_tof       = {r_cnt, hit_fine_i} - w_ref;

    assign o_num = r_count;
    assign ovf_o = r_ovf;
    assign int_o = r_int;

    // Weakest stored entry; strict compare keeps the lowest index on ties.
    always_comb begin
        w_min_idx = '0;
        w_min_int = r_eint[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_eint[i] < w_min_int) begin
                w_min_int = r_eint[i];
                w_min_idx = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and stream outputs; payload is forced to zero when not valid.
    always_comb begin
        w_state_nxt = r_state;
        o_valid     = 1'b0;
        o_data      = '0;
        o_int       = '0;
        o_last      = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_ACQ;
            end
            S_ACQ: begin
                busy_o = 1'b1;
                if (w_term) begin
                    w_state_nxt = ((r_count != '0) || w_hit_acc) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                busy_o  = 1'b1;
                o_valid = 1'b1;
                o_data  = r_tof[r_beat];
                o_int   = r_eint[r_beat];
                o_last  = w_last_beat;
                if (w_hs && w_last_beat) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window counter, hit ranking buffer, drain pointer and status flags.
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_range <= '0;
            r_sfine <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_ovf   <= 1'b0;
            r_int   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tof[i]  <= '0;
                r_eint[i] <= '0;
            end
        end else begin
            r_int <= w_term;
            if (w_start_acc) begin
                r_cnt   <= '0;
                r_range <= range_i;
                r_sfine <= start_fine_i;
                r_count <= '0;
                r_beat  <= '0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_ACQ) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_hit_acc) begin
                    if (!w_full) begin
                        r_tof[r_count[IDX_W-1:0]]  <= w_tof;
                        r_eint[r_count[IDX_W-1:0]] <= hit_int_i;
                        r_count                    <= r_count + NUM_W'(1);
                    end else begin
                        r_ovf <= 1'b1;
                        if (hit_int_i > w_min_int) begin
                            r_tof[w_min_idx]  <= w_tof;
                            r_eint[w_min_idx] <= hit_int_i;
                        end
                    end
                end
            end else if ((r_state == S_DRAIN) && w_hs) begin
                r_beat <= w_last_beat ? '0 : r_beat + IDX_W'(1);
            end
        end
    end

`ifdef TDC_HITCNT_EN
    logic [CNT_W-1:0] r_hits;

    // Saturating count of every hit accepted in ACQ, including dropped ones.
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n)                        r_hits <= '0;
        else if (w_start_acc)              r_hits <= '0;
        else if (w_hit_acc && ~&r_hits)    r_hits <= r_hits + CNT_W'(1);
    end

    assign hits_total_o = r_hits;
`else
    assign hits_total_o = '0;
`endif

endmodule

// File: tb/tb_tdc_multihit_collector.sv
`timescale 1ns/100ps
// Bench for tdc_multihit_collector: hand-computed vector table, directed
// restart/reset/idle-hit sequences and randomized windows against a queue model.
module tb_tdc_multihit_collector;

    localparam int CNT_W  = 10;
    localparam int FINE_W = 5;
    localparam int INT_W  = 5;
    localparam int DEPTH  = 4;
    localparam int NUM_W  = 3;
    localparam int TOF_W  = CNT_W + FINE_W;

    typedef struct {
        int              range;
        int              sf;
        int              nh;
        logic [5:0][9:0] hc;
        logic [5:0][4:0] hf;
        logic [5:0][4:0] hn;
        int              mode;
        int              en;
        int              eovf;
        logic [3:0][14:0] etof;
        logic [3:0][4:0]  eint;
    } vec_t;

    vec_t vt[6];

    logic              clk5 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [FINE_W-1:0] start_fine_i = '0;
    logic              hit_i = 1'b0;
    logic [FINE_W-1:0] hit_fine_i = '0;
    logic [INT_W-1:0]  hit_int_i = '0;
    logic [CNT_W-1:0]  range_i = '0;
    logic [TOF_W-1:0]  o_data;
    logic [INT_W-1:0]  o_int;
    logic [NUM_W-1:0]  o_num;
    logic              o_last;
    logic              o_valid;
    logic              o_ready = 1'b0;
    logic              int_o;
    logic              busy_o;
    logic              ovf_o;
    logic [CNT_W-1:0]  hits_total_o;

    int n_err = 0;
    int n_chk = 0;
    int exp_tof[$];
    int exp_int[$];
    int m_sfine, m_ovf, m_hits;
    bit hv[1024];
    int hfa[1024];
    int hia[1024];

    tdc_multihit_collector #(
        .CNT_W(CNT_W), .FINE_W(FINE_W), .INT_W(INT_W), .DEPTH(DEPTH), .NUM_W(NUM_W)
    ) dut (
        .clk5(clk5), .rst_n(rst_n), .start_i(start_i), .start_fine_i(start_fine_i),
        .hit_i(hit_i), .hit_fine_i(hit_fine_i), .hit_int_i(hit_int_i), .range_i(range_i),
        .o_data(o_data), .o_int(o_int), .o_num(o_num), .o_last(o_last),
        .o_valid(o_valid), .o_ready(o_ready), .int_o(int_o), .busy_o(busy_o),
        .ovf_o(ovf_o), .hits_total_o(hits_total_o)
    );

    always #5 clk5 = ~clk5;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_hits();
`ifdef TDC_HITCNT_EN
        return (m_hits > 1023) ? 1023 : m_hits;
`else
        return 0;
`endif
    endfunction

    task automatic rst_chk(input string tag);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_int"}, o_int, 0);
        chk({tag, "_num"}, o_num, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_irq"}, int_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ovf"}, ovf_o, 0);
        chk({tag, "_hits"}, hits_total_o, 0);
    endtask

    task automatic clear_hits();
        for (int c = 0; c < 1024; c++) hv[c] = 1'b0;
    endtask

    // Spec-level model: tof arithmetic and keep-the-strongest ranking.
    task automatic model_hit(input int c, input int f, input int n);
        int tof, mi;
        tof = ((c * (1 << FINE_W) + f) - ((1 << FINE_W) + m_sfine)) & ((1 << TOF_W) - 1);
        m_hits++;
        if (exp_tof.size() < DEPTH) begin
            exp_tof.push_back(tof);
            exp_int.push_back(n);
        end else begin
            m_ovf = 1;
            mi = 0;
            for (int k = 1; k < DEPTH; k++) if (exp_int[k] < exp_int[mi]) mi = k;
            if (n > exp_int[mi]) begin
                exp_tof[mi] = tof;
                exp_int[mi] = n;
            end
        end
    endtask

    // Called at a falling edge; start is seen at the next rising edge.
    task automatic do_start(input int rng, input int sf);
        start_i = 1'b1;
        range_i = rng[9:0];
        start_fine_i = sf[4:0];
        exp_tof.delete();
        exp_int.delete();
        m_sfine = sf;
        m_ovf = 0;
        m_hits = 0;
        @(negedge clk5);
        start_i = 1'b0;
    endtask

    // Drives the hit schedule for counter values 0..last_c.
    task automatic acq_run(input int last_c, input bit at_end);
        for (int c = 0; c <= last_c; c++) begin
            chk("busy_acq", busy_o, 1);
            chk("int_o_acq", int_o, 0);
            if (hv[c]) begin
                hit_i = 1'b1;
                hit_fine_i = hfa[c][4:0];
                hit_int_i = hia[c][4:0];
                model_hit(c, hfa[c], hia[c]);
            end else begin
                hit_i = 1'b0;
                hit_fine_i = 5'($urandom);
                hit_int_i = 5'($urandom);
            end
            @(negedge clk5);
        end
        hit_i = 1'b0;
        if (at_end) begin
            chk("int_o_pulse", int_o, 1);
            chk("hits_total_end", hits_total_o, exp_hits());
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on beat 1.
    task automatic drain_check(input int mode, input bit noise);
        int n, beat, guard, stall;
        bit pstall, rdy;
        logic [31:0] pd, pi;
        n = exp_tof.size();
        beat = 0; guard = 0; stall = 0; pstall = 0; pd = 0; pi = 0;
        if (n == 0) begin
            chk("no_valid_empty", o_valid, 0);
            chk("idle_empty", busy_o, 0);
            @(negedge clk5);
            chk("int_o_width", int_o, 0);
        end else begin
            while (beat < n && guard < 400) begin
                chk("valid_drain", o_valid, 1);
                chk("int_o_drain", int_o, 32'(guard == 0));
                if (pstall) begin
                    chk("data_hold", o_data, pd);
                    chk("int_hold", o_int, pi);
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = 1'($urandom_range(0, 1));
                    default: begin
                        rdy = !(beat == 1 && stall < 5);
                        if (!rdy) stall++;
                    end
                endcase
                o_ready = rdy;
                if (noise) begin
                    hit_i = 1'($urandom);
                    hit_fine_i = 5'($urandom);
                    hit_int_i = 5'd16;
                    start_i = !rdy;
                    range_i = 10'($urandom);
                    start_fine_i = 5'($urandom);
                end
                if (rdy) begin
                    chk("beat_data", o_data, exp_tof[beat]);
                    chk("beat_int", o_int, exp_int[beat]);
                    chk("beat_last", o_last, 32'(beat == n - 1));
                    chk("beat_num", o_num, n);
                    beat++;
                end
                pstall = !rdy;
                pd = o_data;
                pi = o_int;
                @(negedge clk5);
                guard++;
            end
            o_ready = 1'b0;
            hit_i = 1'b0;
            start_i = 1'b0;
            if (beat < n) chk("drain_timeout", beat, n);
            chk("post_valid", o_valid, 0);
            chk("post_data", o_data, 0);
            chk("post_int", o_int, 0);
            chk("post_last", o_last, 0);
            chk("post_busy", busy_o, 0);
        end
        chk("frame_num", o_num, n);
        chk("frame_ovf", ovf_o, m_ovf);
        chk("hits_total_hold", hits_total_o, exp_hits());
        @(negedge clk5);
    endtask

    task automatic sv(input int i, input int rng, input int sf, input int mode, input int en, input int eovf);
        vt[i].range = rng; vt[i].sf = sf; vt[i].mode = mode;
        vt[i].en = en; vt[i].eovf = eovf; vt[i].nh = 0;
    endtask

    task automatic sh(input int i, input int c, input int f, input int n);
        vt[i].hc[vt[i].nh] = 10'(c);
        vt[i].hf[vt[i].nh] = 5'(f);
        vt[i].hn[vt[i].nh] = 5'(n);
        vt[i].nh++;
    endtask

    task automatic se(input int i, input int k, input int tof, input int n);
        vt[i].etof[k] = 15'(tof);
        vt[i].eint[k] = 5'(n);
    endtask

    task automatic run_vec(input int i);
        clear_hits();
        for (int k = 0; k < vt[i].nh; k++) begin
            hv[vt[i].hc[k]] = 1'b1;
            hfa[vt[i].hc[k]] = int'(vt[i].hf[k]);
            hia[vt[i].hc[k]] = int'(vt[i].hn[k]);
        end
        do_start(vt[i].range, vt[i].sf);
        acq_run(vt[i].range, 1'b1);
        exp_tof.delete();
        exp_int.delete();
        for (int k = 0; k < vt[i].en; k++) begin
            exp_tof.push_back(int'(vt[i].etof[k]));
            exp_int.push_back(int'(vt[i].eint[k]));
        end
        m_ovf = vt[i].eovf;
        drain_check(vt[i].mode, 1'b0);
    endtask

    initial begin
        // Hand-computed frames: tof = 32*counter + fine - (32 + start_fine), mod 2^15.
        sv(0, 20, 3, 0, 2, 0);
        sh(0, 5, 10, 7); sh(0, 9, 1, 2);
        se(0, 0, 135, 7); se(0, 1, 254, 2);
        sv(1, 10, 0, 0, 4, 1);
        sh(1, 1, 0, 3); sh(1, 2, 0, 5); sh(1, 3, 0, 5);
        sh(1, 4, 0, 2); sh(1, 5, 0, 5); sh(1, 6, 0, 9);
        se(1, 0, 160, 9); se(1, 1, 32, 5); se(1, 2, 64, 5); se(1, 3, 128, 5);
        sv(2, 0, 0, 0, 0, 0);
        sv(3, 0, 2, 0, 1, 0);
        sh(3, 0, 7, 4);
        se(3, 0, 32741, 4);
        sv(4, 6, 31, 2, 3, 0);
        sh(4, 2, 0, 1); sh(4, 3, 31, 16); sh(4, 6, 5, 8);
        se(4, 0, 1, 1); se(4, 1, 64, 16); se(4, 2, 134, 8);
        sv(5, 5, 0, 1, 4, 1);
        sh(5, 0, 0, 6); sh(5, 1, 0, 6); sh(5, 2, 0, 6);
        sh(5, 3, 0, 6); sh(5, 4, 0, 6); sh(5, 5, 3, 7);
        se(5, 0, 131, 7); se(5, 1, 0, 6); se(5, 2, 32, 6); se(5, 3, 64, 6);

        #12;
        rst_chk("reset");
        @(negedge clk5);
        rst_n = 1'b1;
        @(negedge clk5);

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            if (i == 0) begin
                // Hits while idle must not touch the held frame status.
                for (int k = 0; k < 3; k++) begin
                    hit_i = 1'b1;
                    hit_int_i = 5'd16;
                    @(negedge clk5);
                end
                hit_i = 1'b0;
                @(negedge clk5);
                chk("idle_hit_ovf", ovf_o, 0);
                chk("idle_hit_num", o_num, 2);
                chk("idle_hit_valid", o_valid, 0);
                chk("idle_hit_total", hits_total_o, exp_hits());
            end
        end

        // Restart at counter 7 with two hits stored.
        clear_hits();
        hv[2] = 1'b1; hfa[2] = 4; hia[2] = 9;
        hv[4] = 1'b1; hfa[4] = 8; hia[4] = 12;
        do_start(15, 0);
        acq_run(6, 1'b0);
        do_start(3, 1);
        clear_hits();
        hv[1] = 1'b1; hfa[1] = 0; hia[1] = 5;
        acq_run(3, 1'b1);
        chk("restart_tof", o_data, 32767);
        drain_check(0, 1'b0);

        // Asynchronous reset while a frame is being drained.
        clear_hits();
        hv[1] = 1'b1; hfa[1] = 1; hia[1] = 3;
        hv[2] = 1'b1; hfa[2] = 2; hia[2] = 4;
        hv[3] = 1'b1; hfa[3] = 3; hia[3] = 5;
        do_start(10, 0);
        acq_run(10, 1'b1);
        o_ready = 1'b0;
        @(negedge clk5);
        @(negedge clk5);
        chk("pre_rst_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1 rst_chk("rst_mid");
        @(negedge clk5);
        rst_n = 1'b1;
        @(negedge clk5);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_valid", o_valid, 0);

        // Randomized windows against the model.
        for (int r = 0; r < 25; r++) begin
            int rng;
            clear_hits();
            rng = $urandom_range(0, 40);
            for (int c = 0; c <= rng; c++) begin
                if ($urandom_range(0, 99) < 45) begin
                    hv[c] = 1'b1;
                    hfa[c] = $urandom_range(0, 31);
                    hia[c] = $urandom_range(0, 16);
                end
            end
            do_start(rng, $urandom_range(0, 31));
            acq_run(rng, 1'b1);
            drain_check($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Full-range window with a hit every cycle: counter saturation.
        clear_hits();
        for (int c = 0; c < 1024; c++) begin
            hv[c] = 1'b1;
            hfa[c] = $urandom_range(0, 31);
            hia[c] = $urandom_range(0, 16);
        end
        do_start(1023, $urandom_range(0, 31));
        acq_run(1023, 1'b1);
        drain_check(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
